// File: rtl/blink_pkg.sv
// Shared definitions for the blink-divider link: FSM state encoding and the
// divide value both the blinker and this monitor must agree on.
package blink_pkg;

    localparam int unsigned EXPECTED_HALF_DEFAULT = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for the asynchronous light line plus a one-cycle
// toggle pulse comparing the synchronized value with its previous sample.
module sync_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign o_edge = r_sync2 ^ r_prev;

endmodule

// File: rtl/blink_monitor.sv
// Measures light half-periods in clk cycles, checks them against the expected
// divide value and tracks lock.
//
// state      | meaning
// ST_IDLE    | line stopped or never seen; next edge arms the interval counter
// ST_MEASURE | reporting intervals, counting consecutive in-tolerance ones
// ST_LOCKED  | enough good intervals seen; violations and timeouts flag errors
module blink_monitor
    import blink_pkg::*;
#(
    parameter int unsigned EXPECTED_HALF = EXPECTED_HALF_DEFAULT,
    parameter int unsigned TOL           = 1,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_light,
    output logic [CNT_W-1:0] o_half_period,
    output logic             o_period_valid,
    output logic             o_locked,
    output logic             o_error,
    output logic [7:0]       o_err_count
);

    localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  TOL_LO    = CNT_W'(EXPECTED_HALF - TOL);
    localparam logic [CNT_W-1:0]  TOL_HI    = CNT_W'(EXPECTED_HALF + TOL);
    localparam logic [CNT_W-1:0]  TIMEOUT   = CNT_W'(EXPECTED_HALF + TOL + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);

    state_e              r_state;
    state_e              w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [GOOD_W-1:0]   r_good_cnt;
    logic [GOOD_W-1:0]   w_good_next;
    logic                w_edge;
    logic                w_in_tol;
    logic                w_report;
    logic                w_error;

    logic [CNT_W-1:0]    r_half_period;
    logic                r_period_valid;
    logic                r_locked;
    logic                r_error;
    logic [7:0]          r_err_count;

    sync_edge_det u_sync_edge_det (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_light),
        .o_edge  (w_edge)
    );

    assign w_in_tol = (r_cnt >= TOL_LO) && (r_cnt <= TOL_HI);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // An edge always wins over the timeout compares in the same cycle.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_edge) w_next_state = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (w_edge) begin
                    if (w_in_tol && (r_good_cnt == GOOD_LAST)) w_next_state = ST_LOCKED;
                end else if (r_cnt == CNT_MAX) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_edge) begin
                    if (!w_in_tol) w_next_state = ST_MEASURE;
                end else if (r_cnt == TIMEOUT) begin
                    w_next_state = ST_MEASURE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_report    = 1'b0;
        w_error     = 1'b0;
        w_good_next = r_good_cnt;
        if (w_edge) begin
            w_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (r_cnt == CNT_MAX) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + 1'b1;
        end
        unique case (r_state)
            ST_IDLE: begin
                w_good_next = '0;
                if (!w_edge) w_cnt_next = '0;
            end
            ST_MEASURE: begin
                if (w_edge) begin
                    w_report    = 1'b1;
                    w_good_next = w_in_tol ? r_good_cnt + 1'b1 : '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_cnt_next = '0;
                end
            end
            ST_LOCKED: begin
                if (w_edge) begin
                    w_report = 1'b1;
                    if (!w_in_tol) begin
                        w_error     = 1'b1;
                        w_good_next = '0;
                    end
                end else if (r_cnt == TIMEOUT) begin
                    w_error     = 1'b1;
                    w_good_next = '0;
                end
            end
            default: begin
                w_cnt_next  = '0;
                w_good_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt          <= '0;
            r_good_cnt     <= '0;
            r_half_period  <= '0;
            r_period_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_error        <= 1'b0;
            r_err_count    <= '0;
        end else begin
            r_cnt          <= w_cnt_next;
            r_good_cnt     <= w_good_next;
            r_period_valid <= w_report;
            r_locked       <= (w_next_state == ST_LOCKED);
            r_error        <= w_error;
            if (w_report) r_half_period <= r_cnt;
            if (w_error && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign o_half_period  = r_half_period;
    assign o_period_valid = r_period_valid;
    assign o_locked       = r_locked;
    assign o_error        = r_error;
    assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_blink_monitor.sv
// Drives directed and random light toggle patterns into blink_monitor and
// compares every output each cycle against a timestamp-based reference model.
module tb_blink_monitor;

    localparam int EH    = 9;
    localparam int TOLV  = 1;
    localparam int LOCKN = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst_v = 1'b1;
    logic          light_v = 1'b0;
    logic [CW-1:0] o_half_period;
    logic          o_period_valid;
    logic          o_locked;
    logic          o_error;
    logic [7:0]    o_err_count;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: mode 0 idle, 1 measuring, 2 locked
    int m_cyc = 0;
    int m_mode = 0;
    int m_last = 0;
    int m_streak = 0;
    bit m_hist[$];
    int e_hp = 0;
    int e_pv = 0;
    int e_err = 0;
    int e_lock = 0;
    int e_cnt = 0;

    blink_monitor #(
        .EXPECTED_HALF (EH),
        .TOL           (TOLV),
        .LOCK_COUNT    (LOCKN),
        .CNT_W         (CW)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst_v),
        .i_light        (light_v),
        .o_half_period  (o_half_period),
        .o_period_valid (o_period_valid),
        .o_locked       (o_locked),
        .o_error        (o_error),
        .o_err_count    (o_err_count)
    );

    always #5 clk = ~clk;

    function automatic bit in_tol(input int iv);
        return (iv >= EH - TOLV) && (iv <= EH + TOLV);
    endfunction

    // Advances the model by the posedge about to happen with the current inputs.
    task automatic model_step();
        bit e;
        int iv;
        m_cyc++;
        if (rst_v) begin
            m_hist = '{1'b0, 1'b0, 1'b0, 1'b0};
            m_mode = 0; m_streak = 0; m_last = 0;
            e_hp = 0; e_pv = 0; e_err = 0; e_lock = 0; e_cnt = 0;
            return;
        end
        m_hist.push_front(light_v);
        void'(m_hist.pop_back());
        e = m_hist[2] ^ m_hist[3];
        e_pv = 0;
        e_err = 0;
        iv = m_cyc - m_last;
        if (iv > 255) iv = 255;
        case (m_mode)
            0: if (e) begin m_mode = 1; m_last = m_cyc; m_streak = 0; end
            1: begin
                if (e) begin
                    e_pv = 1; e_hp = iv; m_last = m_cyc;
                    if (in_tol(iv)) begin
                        m_streak++;
                        if (m_streak == LOCKN) m_mode = 2;
                    end else m_streak = 0;
                end else if (iv == 255) m_mode = 0;
            end
            default: begin
                if (e) begin
                    e_pv = 1; e_hp = iv; m_last = m_cyc;
                    if (!in_tol(iv)) begin e_err = 1; m_mode = 1; m_streak = 0; end
                end else if (iv == EH + TOLV + 1) begin
                    e_err = 1; m_mode = 1; m_streak = 0;
                end
            end
        endcase
        e_lock = (m_mode == 2) ? 1 : 0;
        if (e_err == 1 && e_cnt < 255) e_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, m_cyc, got, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("period_valid", {31'd0, o_period_valid}, e_pv);
        chk("half_period", {24'd0, o_half_period}, e_hp);
        chk("error", {31'd0, o_error}, e_err);
        chk("locked", {31'd0, o_locked}, e_lock);
        chk("err_count", {24'd0, o_err_count}, e_cnt);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) tick();
        light_v = ~light_v;
    endtask

    initial begin
        m_hist = '{1'b0, 1'b0, 1'b0, 1'b0};
        rst_v = 1'b1;
        light_v = 1'b0;
        tick();
        tick();
        rst_v = 1'b0;
        tick();

        // nominal toggling from reset: first edge arms, lock after the fifth
        light_v = 1'b1;
        for (int i = 0; i < 8; i++) gap(EH);
        chk("nominal_locked", {31'd0, o_locked}, 32'd1);

        // one long interval while locked, then relock
        gap(12);
        gap(EH);
        chk("violation_unlock", {31'd0, o_locked}, 32'd0);
        chk("violation_count", {24'd0, o_err_count}, 32'd1);
        for (int i = 0; i < 4; i++) gap(EH);
        tick(); tick(); tick();
        chk("relock", {31'd0, o_locked}, 32'd1);

        // line stops while locked: timeout error, then idle, then re-arm
        for (int i = 0; i < 20; i++) tick();
        chk("timeout_unlock", {31'd0, o_locked}, 32'd0);
        chk("timeout_count", {24'd0, o_err_count}, 32'd2);
        for (int i = 0; i < 260; i++) tick();
        light_v = ~light_v;
        for (int i = 0; i < 6; i++) gap(EH);

        // alternating 8/10 intervals, then 7 and 11 while measuring
        for (int i = 0; i < 8; i++) gap((i % 2 == 0) ? 8 : 10);
        for (int i = 0; i < 300; i++) tick();
        light_v = ~light_v;
        gap(EH); gap(EH); gap(7); gap(11); gap(EH); gap(EH);
        for (int i = 0; i < 4; i++) gap(EH);
        tick(); tick(); tick();
        chk("after_7_11_locked", {31'd0, o_locked}, 32'd1);

        // reset while locked with light high
        if (light_v == 1'b0) gap(EH);
        for (int i = 0; i < 3; i++) tick();
        rst_v = 1'b1;
        tick();
        chk("rst_locked", {31'd0, o_locked}, 32'd0);
        chk("rst_err_count", {24'd0, o_err_count}, 32'd0);
        rst_v = 1'b0;
        for (int i = 0; i < 6; i++) gap(EH);

        // random intervals with occasional long stalls
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) gap(300);
            else gap(int'($urandom_range(5, 14)));
        end

        // repeated forced violations to saturate the error counter
        for (int i = 0; i < 6; i++) gap(EH);
        for (int i = 0; i < 300; i++) begin
            gap(12);
            for (int j = 0; j < 4; j++) gap(EH);
        end
        for (int i = 0; i < 5; i++) tick();
        chk("err_count_sat", {24'd0, o_err_count}, 32'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
